// File: rtl/set_bit_serializer_pkg.sv
// Shared types for set_bit_serializer: FSM state encoding and scan-order constants.
package set_bit_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic ORDER_LSB = 1'b0;
    localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/set_bit_serializer_bit_pick.sv
// bit_pick: combinational selector of the lowest or highest set bit of a word,
// returning its index, the isolated one-hot bit and a single-bit-remaining flag.
module bit_pick
    import set_bit_serializer_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] word,
    input  logic             order,
    output logic [WIDTH-1:0] bit_mask,
    output logic [IDX_W-1:0] idx,
    output logic             single
);

    // The loop direction is chosen so that the last assignment wins with the wanted bit.
    always_comb begin
        idx = '0;
        if (order == ORDER_MSB) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (word[i]) idx = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (word[i]) idx = IDX_W'(i);
            end
        end
    end

    assign bit_mask = (|word) ? (WIDTH'(1) << idx) : '0;
    assign single   = (|word) && ((word & (word - WIDTH'(1))) == '0);

endmodule

// File: rtl/set_bit_serializer.sv
// set_bit_serializer: streams the set-bit positions of an accepted word, one beat per bit.
// Optional macro SET_BIT_SERIALIZER_COUNT_EN adds cnt_o (popcount) and beat_num_o (beat ordinal).
module set_bit_serializer
    import set_bit_serializer_pkg::*;
#(
    parameter int  WIDTH = 32,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             msb_first_i,
    input  logic             data_val_i,
    output logic             data_ready_o,
    output logic [IDX_W-1:0] idx_o,
    output logic [WIDTH-1:0] mask_o,
    output logic             idx_last_o,
    output logic             idx_val_o,
    input  logic             idx_ready_i,
    output logic             empty_o
`ifdef SET_BIT_SERIALIZER_COUNT_EN
    ,
    output logic [IDX_W:0]   cnt_o,
    output logic [IDX_W:0]   beat_num_o
`endif
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             order_q, order_d;
    logic             empty_q, empty_d;

    logic [WIDTH-1:0] pick_mask;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_single;
    logic             accept;
    logic             xfer;

    assign accept = data_val_i && (state_q == ST_IDLE);
    assign xfer   = idx_ready_i && (state_q == ST_BURST);

    bit_pick #(.WIDTH(WIDTH)) u_pick (
        .word     (remaining_q),
        .order    (order_q),
        .bit_mask (pick_mask),
        .idx      (pick_idx),
        .single   (pick_single)
    );

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        order_d     = order_q;
        empty_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (data_val_i) begin
                    remaining_d = data_i;
                    order_d     = msb_first_i;
                    empty_d     = (data_i == '0);
                    if (data_i != '0) state_d = ST_BURST;
                end
            end
            ST_BURST: begin
                if (idx_ready_i) begin
                    remaining_d = remaining_q & ~pick_mask;
                    if (pick_single) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            order_q     <= ORDER_LSB;
            empty_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            order_q     <= order_d;
            empty_q     <= empty_d;
        end
    end

    // Beat fields come straight from the remaining register, so they hold while stalled.
    assign data_ready_o = (state_q == ST_IDLE);
    assign idx_val_o    = (state_q == ST_BURST);
    assign idx_o        = pick_idx;
    assign mask_o       = pick_mask;
    assign idx_last_o   = pick_single;
    assign empty_o      = empty_q;

`ifdef SET_BIT_SERIALIZER_COUNT_EN
    logic [IDX_W:0] word_pop;
    logic [IDX_W:0] cnt_q;
    logic [IDX_W:0] beat_q;

    always_comb begin
        word_pop = '0;
        for (int i = 0; i < WIDTH; i++) begin
            word_pop = word_pop + (IDX_W + 1)'(data_i[i]);
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q  <= '0;
            beat_q <= '0;
        end else begin
            if (accept) begin
                cnt_q  <= word_pop;
                beat_q <= (data_i != '0) ? (IDX_W + 1)'(1) : '0;
            end else if (xfer) begin
                beat_q <= pick_single ? '0 : beat_q + (IDX_W + 1)'(1);
            end
        end
    end

    assign cnt_o      = cnt_q;
    assign beat_num_o = beat_q;
`endif

endmodule

// File: tb/tb_set_bit_serializer.sv
// Scoreboard bench for set_bit_serializer at WIDTH=8; beats are predicted when a word is driven
// and compared every cycle a beat is valid. Optional fields checked when SET_BIT_SERIALIZER_COUNT_EN is set.
module tb_set_bit_serializer;
    import set_bit_serializer_pkg::*;

    localparam int WIDTH = 8;

    typedef struct packed {
        logic [2:0] idx;
        logic [7:0] mask;
        logic       last;
        logic [3:0] cnt;
        logic [3:0] num;
    } beat_t;

    logic       clk_i = 1'b0;
    logic       arst_i;
    logic [7:0] data_i;
    logic       msb_first_i;
    logic       data_val_i;
    logic       data_ready_o;
    logic [2:0] idx_o;
    logic [7:0] mask_o;
    logic       idx_last_o;
    logic       idx_val_o;
    logic       idx_ready_i;
    logic       empty_o;
`ifdef SET_BIT_SERIALIZER_COUNT_EN
    logic [3:0] cnt_o;
    logic [3:0] beat_num_o;
`endif

    int    n_tests = 0;
    int    n_fail  = 0;
    int    exp_empty = 0;
    bit    mon_en = 1'b0;
    bit    after_last = 1'b0;
    beat_t sb[$];

    set_bit_serializer #(.WIDTH(WIDTH)) dut (
        .clk_i        (clk_i),
        .arst_i       (arst_i),
        .data_i       (data_i),
        .msb_first_i  (msb_first_i),
        .data_val_i   (data_val_i),
        .data_ready_o (data_ready_o),
        .idx_o        (idx_o),
        .mask_o       (mask_o),
        .idx_last_o   (idx_last_o),
        .idx_val_o    (idx_val_o),
        .idx_ready_i  (idx_ready_i),
        .empty_o      (empty_o)
`ifdef SET_BIT_SERIALIZER_COUNT_EN
        ,
        .cnt_o        (cnt_o),
        .beat_num_o   (beat_num_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: walk the word in scan order and queue one beat per set bit.
    task automatic push_word(input logic [7:0] w, input logic msb);
        int    pop;
        int    k;
        int    bit_i;
        beat_t b;
        pop = 0;
        k   = 0;
        for (int i = 0; i < 8; i++) pop += int'(w[i]);
        for (int j = 0; j < 8; j++) begin
            bit_i = msb ? 7 - j : j;
            if (w[bit_i]) begin
                k++;
                b.idx  = 3'(bit_i);
                b.mask = 8'(1) << bit_i;
                b.last = (k == pop);
                b.cnt  = 4'(pop);
                b.num  = 4'(k);
                sb.push_back(b);
            end
        end
        if (pop == 0) exp_empty++;
    endtask

    task automatic send(input logic [7:0] w, input logic msb);
        int guard;
        guard = 0;
        while (!data_ready_o && guard < 200) begin
            @(posedge clk_i); #1;
            guard++;
        end
        if (!data_ready_o) check("send_ready_timeout", 32'(data_ready_o), 1);
        data_i      = w;
        msb_first_i = msb;
        data_val_i  = 1'b1;
        push_word(w, msb);
        @(posedge clk_i); #1;
        data_val_i  = 1'b0;
        data_i      = 8'($urandom);
        msb_first_i = 1'($urandom);
    endtask

    task automatic wait_idle(input string tag);
        int guard;
        guard = 0;
        repeat (2) @(negedge clk_i);
        while (!(data_ready_o && sb.size() == 0) && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        @(negedge clk_i);
        check({tag, "_idle"}, 32'(data_ready_o), 1);
        check({tag, "_sb_drained"}, sb.size(), 0);
        check({tag, "_empty_seen"}, exp_empty, 0);
    endtask

    // Monitor: compare the head beat every valid cycle (so stalls must hold it), pop on transfer.
    initial begin
        beat_t exp;
        forever begin
            @(negedge clk_i);
            if (mon_en && !arst_i) begin
                if (after_last) begin
                    check("ready_after_last", {30'd0, data_ready_o, idx_val_o}, 2'b10);
                    after_last = 1'b0;
                end
                if (empty_o) begin
                    check("empty_expected", 32'(exp_empty > 0), 1);
                    if (exp_empty > 0) exp_empty--;
                end
                if (idx_val_o) begin
                    check("beat_pending", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        exp = sb[0];
                        check("beat", {idx_o, mask_o, idx_last_o}, {exp.idx, exp.mask, exp.last});
`ifdef SET_BIT_SERIALIZER_COUNT_EN
                        check("cnt", 32'(cnt_o), 32'(exp.cnt));
                        check("beat_num", 32'(beat_num_o), 32'(exp.num));
`endif
                        if (idx_ready_i) begin
                            void'(sb.pop_front());
                            if (exp.last) after_last = 1'b1;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        arst_i      = 1'b1;
        data_i      = '0;
        msb_first_i = ORDER_LSB;
        data_val_i  = 1'b0;
        idx_ready_i = 1'b1;
        #2;
        check("reset_outputs", {idx_val_o, idx_last_o, idx_o, mask_o, empty_o}, 0);
        check("reset_ready", 32'(data_ready_o), 1);
`ifdef SET_BIT_SERIALIZER_COUNT_EN
        check("reset_cnt", {cnt_o, beat_num_o}, 0);
`endif
        #10 arst_i = 1'b0;
        @(negedge clk_i);
        check("ready_after_reset", 32'(data_ready_o), 1);
        mon_en = 1'b1;

        // LSB-first then MSB-first on the same word.
        send(8'b1010_0100, ORDER_LSB);
        wait_idle("lsb_a4");
        send(8'b1010_0100, ORDER_MSB);
        wait_idle("msb_a4");

        // Single zero word, then back-to-back zero words.
        send(8'h00, ORDER_LSB);
        wait_idle("zero_single");
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            check("zero_ready", 32'(data_ready_o), 1);
            data_i     = 8'h00;
            data_val_i = 1'b1;
            push_word(8'h00, ORDER_LSB);
            @(posedge clk_i); #1;
        end
        data_val_i = 1'b0;
        wait_idle("zero_b2b");

        // All ones with the first beat stalled for three cycles.
        idx_ready_i = 1'b0;
        send(8'hFF, ORDER_LSB);
        repeat (3) begin
            @(posedge clk_i); #1;
        end
        idx_ready_i = 1'b1;
        wait_idle("ff_stall");

        // Abort mid-burst after beats 4 and 5 have transferred.
        send(8'hF0, ORDER_LSB);
        repeat (2) begin
            @(posedge clk_i); #1;
        end
        check("abort_remaining", sb.size(), 2);
        arst_i = 1'b1;
        sb.delete();
        after_last = 1'b0;
        #1;
        check("abort_outputs", {idx_val_o, idx_last_o, idx_o, mask_o, empty_o}, 0);
        @(posedge clk_i); #3;
        arst_i = 1'b0;
        @(negedge clk_i);
        check("abort_ready", 32'(data_ready_o), 1);
        repeat (5) @(negedge clk_i);
        check("abort_no_stale", 32'(idx_val_o), 0);
        send(8'h81, ORDER_MSB);
        wait_idle("post_abort");

`ifdef SET_BIT_SERIALIZER_COUNT_EN
        send(8'b0110_1001, ORDER_LSB);
        wait_idle("count_69");
`endif

        // Random words, random order, random consumer back-pressure.
        for (int n = 0; n < 12; n++) begin
            send(8'($urandom), 1'($urandom));
            for (int c = 0; c < 200; c++) begin
                if (data_ready_o) break;
                idx_ready_i = 1'($urandom_range(0, 1));
                @(posedge clk_i); #1;
            end
            idx_ready_i = 1'b1;
            wait_idle("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/set_bit_serializer.md
# set_bit_serializer

Decodes a WIDTH-bit word into a serial stream of its set-bit positions, one beat per set bit. Each beat carries the bit index and the matching isolated one-hot mask, with a last flag on the final beat. Scan order is selectable per word: lowest bit first or highest bit first. Sits downstream of word producers such as the priority encoder path and feeds index-driven consumers (arbiters, interrupt dispatch) through a valid/ready handshake.

## Interface
- WIDTH, 32: input word width; must be ≥ 2.
- IDX_W, $clog2(WIDTH): index width; localparam, not overridable.
- clk_i  in  1  clock; all logic is posedge.
- arst_i  in  1  reset; asynchronous, active-high.
- data_i  in  WIDTH  word to decode.
- msb_first_i  in  1  scan order for this word: 0 = lowest bit first, 1 = highest bit first. Sampled with data_i.
- data_val_i  in  1  data_i/msb_first_i valid.
- data_ready_o  out  1  block can accept a word.
- idx_o  out  IDX_W  bit index of the current beat.
- mask_o  out  WIDTH  one-hot mask, 1 << idx_o.
- idx_last_o  out  1  current beat is the last set bit of the word.
- idx_val_o  out  1  beat valid.
- idx_ready_i  in  1  consumer accepts the beat.
- empty_o  out  1  one-cycle pulse when an all-zero word is accepted.

## Operation
- Two states.
  - IDLE: data_ready_o = 1, idx_val_o = 0.
  - BURST: data_ready_o = 0, idx_val_o = 1.
- Accept occurs when data_val_i && data_ready_o.
  - The word is latched into a remaining register and the order bit into an order register.
  - If the word is nonzero: go to BURST and present the first beat (lowest or highest set bit per order).
  - If the word is zero: stay in IDLE, pulse empty_o next cycle, emit no beats.
- Beat contents:
  - idx_o = index of the selected bit of remaining.
  - mask_o = that bit isolated.
  - idx_last_o = 1 when remaining has exactly one set bit.
- A beat transfers when idx_val_o && idx_ready_i.
  - The selected bit is cleared from remaining and the next beat is presented.
  - After the last beat transfers, return to IDLE.
- Holding rules:
  - While idx_val_o = 1 and idx_ready_i = 0, idx_o, mask_o and idx_last_o are held stable.
  - idx_val_o never drops without a transfer.
- data_i is ignored outside an accept.
- Reset values (all outputs):
  - state = IDLE; remaining = 0.
  - data_ready_o = 1 after reset is released.
  - idx_val_o = 0, idx_last_o = 0, idx_o = 0, mask_o = 0, empty_o = 0.
- arst_i mid-burst aborts immediately. The remaining bits are discarded and no partial last beat is emitted.

## Timing
- All outputs are registered; there is no combinational path from data_i or idx_ready_i to any output.
- Latency: word accepted in cycle N, first beat valid in cycle N+1. An all-zero word gives empty_o high in cycle N+1.
- Throughput: one beat per cycle while idx_ready_i = 1. A word with K set bits occupies K cycles of BURST.
- data_ready_o rises in the cycle after the last beat transfers, so there is one idle cycle between bursts.
- Back-to-back zero words can be accepted every cycle; empty_o pulses once per zero word.

## Configuration
- Macro SET_BIT_SERIALIZER_COUNT_EN.
- Defined:
  - Adds output cnt_o, width IDX_W+1, holding the popcount of the accepted word.
  - cnt_o is registered at accept and held until the next accept.
  - It is 0 for a zero word and 0 at reset.
  - Adds output beat_num_o, width IDX_W+1: 1-based ordinal of the current beat, 0 in IDLE.
- Undefined: neither port exists; all other behaviour is identical.

## Structure
- Package set_bit_serializer_pkg holds:
  - the state enum type;
  - the order encoding constants ORDER_LSB = 1'b0 and ORDER_MSB = 1'b1.
- One combinational sub-module, bit_pick.
  - Input: a WIDTH-bit word and the order bit.
  - Outputs: the isolated bit, its index, and a single-bit-remaining flag.
  - The top level instantiates it once, on the remaining register.

## Test plan
- WIDTH=8, data_i = 8'b1010_0100, LSB-first, idx_ready_i held 1 → idx_o 2, 5, 7 on consecutive cycles; mask_o 8'h04, 8'h20, 8'h80; idx_last_o high only on 7; data_ready_o = 1 on the following cycle.
- Same word, MSB-first → idx_o 7, 5, 2; idx_last_o high on 2.
- data_i = 8'h00 → no idx_val_o; empty_o high for exactly one cycle; data_ready_o stays 1.
- data_i = 8'hFF LSB-first with idx_ready_i low for 3 cycles after the first beat → idx_o = 0 held for 4 cycles, then 1..7 back to back, 8 beats total.
- arst_i asserted mid-burst of 8'hF0, after idx_o = 5 has transferred → idx_val_o and all outputs drop asynchronously to reset values; after release, data_ready_o = 1 and no stale beats appear.
- With SET_BIT_SERIALIZER_COUNT_EN defined, data_i = 8'b0110_1001 → cnt_o = 4 from the first beat; beat_num_o = 1, 2, 3, 4.
